// File: rtl/fpall_issue_arbiter.sv
// Round-robin issue arbiter feeding one shared FP add/mul unit and steering results back by tag.
// Define FPALL_ARB_RR_EN for round-robin grants; leave it undefined for fixed lowest-index priority.

package fpall_pkg;
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } opcode_e;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fmt_e;
endpackage

module fpall_issue_arbiter
  import fpall_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  input  opcode_e            i_req_opcode [NUM_REQ],
  input  fmt_e               i_req_fmt    [NUM_REQ],
  input  logic [31:0]        i_req_x      [NUM_REQ],
  input  logic [31:0]        i_req_y      [NUM_REQ],
  output opcode_e            o_fpu_opcode,
  output fmt_e               o_fpu_fmt,
  output logic [31:0]        o_fpu_x,
  output logic [31:0]        o_fpu_y,
  output logic               o_fpu_valid,
  input  logic [31:0]        i_fpu_r,
  output logic [NUM_REQ-1:0] o_rsp_valid,
  output logic [31:0]        o_rsp_data,
  output logic [31:0]        o_issue_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic             hs;

  opcode_e          fpu_opcode_q;
  fmt_e             fpu_fmt_q;
  logic [31:0]      fpu_x_q;
  logic [31:0]      fpu_y_q;
  logic             fpu_valid_q;
  logic [31:0]      issue_cnt_q;

  logic [FPU_LAT:0]            tag_vld_q;
  logic [FPU_LAT:0][IDX_W-1:0] tag_idx_q;

`ifdef FPALL_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  // Walk the requesters in circular order starting at rr_ptr; first valid wins.
  always_comb begin
    logic [CW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!grant_any && i_req_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && i_req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Grants are withheld during reset so nothing is accepted that would be dropped.
  assign hs = grant_any && !i_rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign o_req_ready[gi] = hs && (grant_idx == IDX_W'(gi));
  end

  // Operand registers hold their last value when idle to avoid toggling the unit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpu_valid_q  <= 1'b0;
      fpu_opcode_q <= OP_ADD;
      fpu_fmt_q    <= FP32;
      fpu_x_q      <= '0;
      fpu_y_q      <= '0;
    end else begin
      fpu_valid_q <= hs;
      if (hs) begin
        fpu_opcode_q <= i_req_opcode[grant_idx];
        fpu_fmt_q    <= i_req_fmt[grant_idx];
        fpu_x_q      <= i_req_x[grant_idx];
        fpu_y_q      <= i_req_y[grant_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issue_cnt_q <= '0;
    end else if (hs) begin
      issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  // Owner tags travel alongside the unit's fixed latency; reset discards in-flight owners.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q[0] <= hs;
      tag_idx_q[0] <= grant_idx;
      for (int s = 1; s <= FPU_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign o_rsp_valid[gi] = tag_vld_q[FPU_LAT] && (tag_idx_q[FPU_LAT] == IDX_W'(gi));
  end

  assign o_rsp_data   = tag_vld_q[FPU_LAT] ? i_fpu_r : 32'd0;
  assign o_fpu_opcode = fpu_opcode_q;
  assign o_fpu_fmt    = fpu_fmt_q;
  assign o_fpu_x      = fpu_x_q;
  assign o_fpu_y      = fpu_y_q;
  assign o_fpu_valid  = fpu_valid_q;
  assign o_issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_fpall_issue_arbiter.sv
// Scoreboard bench for fpall_issue_arbiter with a stand-in shared unit of fixed latency.
// Grant order follows FPALL_ARB_RR_EN in the same way the design does.

module tb_fpall_issue_arbiter;
  import fpall_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  opcode_e       req_op  [N];
  fmt_e          req_fmt [N];
  logic [31:0]   req_x   [N];
  logic [31:0]   req_y   [N];
  opcode_e       fpu_op;
  fmt_e          fpu_fmt;
  logic [31:0]   fpu_x, fpu_y, fpu_r, fpu_comb;
  logic          fpu_valid;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic [31:0]   issue_cnt;

  always #5 clk = ~clk;

  fpall_issue_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_opcode(req_op), .i_req_fmt(req_fmt), .i_req_x(req_x), .i_req_y(req_y),
    .o_fpu_opcode(fpu_op), .o_fpu_fmt(fpu_fmt), .o_fpu_x(fpu_x), .o_fpu_y(fpu_y),
    .o_fpu_valid(fpu_valid), .i_fpu_r(fpu_r),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_issue_cnt(issue_cnt)
  );

  // Stand-in unit: a distinctive function of all operands, so misrouted data shows up.
  function automatic logic [31:0] fpu_sig(input opcode_e op, input fmt_e f,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [31:0] m;
    m = x * 32'd3;
    return m ^ {y[15:0], y[31:16]} ^ {30'd0, f == FP16, op == OP_MUL};
  endfunction

  assign fpu_comb = fpu_sig(fpu_op, fpu_fmt, fpu_x, fpu_y);

  if (LAT == 0) begin : g_fpu_comb
    assign fpu_r = fpu_comb;
  end else begin : g_fpu_pipe
    logic [31:0] dly [LAT];
    always @(posedge clk) begin
      dly[0] <= fpu_comb;
      for (int s = 1; s < LAT; s++) dly[s] <= dly[s-1];
    end
    assign fpu_r = dly[LAT-1];
  end

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_r;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ptr_m = 0;
  int          last_win = -1;
  logic [31:0] cnt_m = 32'd0;
  logic [31:0] lx = 32'd0, ly = 32'd0;
  opcode_e     lop = OP_ADD;
  fmt_e        lfmt = FP32;
  logic        lval = 1'b0;
  logic [N-1:0] pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Winner = first valid requester in circular order from the model's pointer.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input opcode_e op, input fmt_e f,
                         input logic [31:0] x, input logic [31:0] y);
    req_op[k] = op; req_fmt[k] = f; req_x[k] = x; req_y[k] = y;
  endtask

  task automatic rand_req(input int k);
    set_req(k, $urandom_range(0, 1) ? OP_MUL : OP_ADD, $urandom_range(0, 1) ? FP16 : FP32,
            $urandom, $urandom);
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the reference model.
  task automatic step();
    int          w;
    logic [31:0] er;
    rsp_t        r;
    @(negedge clk);
    w  = rst ? -1 : pick(req_valid, ptr_m);
    er = (w >= 0) ? (32'd1 << w) : 32'd0;
    chk(rst ? "ready_in_reset" : "ready", 32'(req_ready), er);
    chk("fpu_valid", {31'd0, fpu_valid}, {31'd0, lval});
    chk("fpu_opcode", {31'd0, fpu_op}, {31'd0, lop});
    chk("fpu_fmt", {31'd0, fpu_fmt}, {31'd0, lfmt});
    chk("fpu_x", fpu_x, lx);
    chk("fpu_y", fpu_y, ly);
    chk("issue_cnt", issue_cnt, cnt_m);
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      ptr_m = 0; cnt_m = 32'd0; lx = 32'd0; ly = 32'd0;
      lop = OP_ADD; lfmt = FP32; lval = 1'b0;
    end else if (w >= 0) begin
      r.idx  = w;
      r.data = fpu_sig(req_op[w], req_fmt[w], req_x[w], req_y[w]);
      r.due  = cyc + LAT;
      exp_q.push_back(r);
      lval = 1'b1; lop = req_op[w]; lfmt = req_fmt[w]; lx = req_x[w]; ly = req_y[w];
      cnt_m = cnt_m + 32'd1;
`ifdef FPALL_ARB_RR_EN
      ptr_m = (w + 1) % N;
`endif
    end else begin
      lval = 1'b0;
    end
    last_win = w;
    #1;
  endtask

  // Response monitor: every cycle either the due entry arrives or the output is quiet.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          mon_r = exp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'd1 << mon_r.idx);
          chk("rsp_data", rsp_data, mon_r.data);
          $display("rsp req%0d data=%08h cycle %0d", mon_r.idx, rsp_data, cyc);
        end else begin
          chk("rsp_idle_valid", 32'(rsp_valid), 32'd0);
          chk("rsp_idle_data", rsp_data, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    for (int k = 0; k < N; k++) set_req(k, OP_ADD, FP32, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    // Reset holds grants low even with every requester asking.
    req_valid = '1;
    repeat (2) step();
    rst = 1'b0;
    req_valid = '0;
    step();

    // Single FP32 add from requester 0.
    set_req(0, OP_ADD, FP32, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // Full contention for 8 cycles.
    for (int k = 0; k < N; k++) set_req(k, OP_MUL, FP32, 32'h40000000 + 32'(k), 32'h40400000);
    req_valid = '1;
    repeat (8) step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // Two persistent requesters.
    req_valid = 4'b0101;
    repeat (8) step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // FP16 add through the latency pipe.
    set_req(1, OP_ADD, FP16, 32'h00003C00, 32'h00003C00);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // Reset one cycle after issuing from requester 3; its result must never appear.
    set_req(3, OP_MUL, FP32, 32'h12345678, 32'h9ABCDEF0);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0001;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0110;
    step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // Isolated pulses separated by two idle cycles.
    repeat (3) begin
      rand_req(2);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      repeat (2) step();
    end

    // Random traffic: requesters hold until granted, occasional reset.
    pend = '0;
    last_win = -1;
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        if (last_win == k) pend[k] = 1'b0;
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          rand_req(k);
        end
      end
      req_valid = pend;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (LAT + 3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpall_issue_arbiter.md
# fpall_issue_arbiter

Round-robin issue arbiter that shares one `fpall_shared` FP unit between `NUM_REQ` independent requesters (FP32/FP16 add/mul). Accepts at most one operation per cycle through per-requester valid/ready handshakes and registers the winning operands into the unit. Tracks each in-flight operation's owner through a fixed-latency tag pipeline and steers the unit's result back to that requester. Sits between client issue logic and the single `fpall_shared` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `FPU_LAT`, 0: cycles from `o_fpu_*` change to a valid `i_fpu_r` (0 = combinational unit).

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_req_valid` in [NUM_REQ]: requester k has an operation.
- `o_req_ready` in/out out [NUM_REQ]: grant; at most one bit high.
- `i_req_opcode` in [NUM_REQ] x `fpall_pkg` opcode type: OP_ADD / OP_MUL.
- `i_req_fmt` in [NUM_REQ] x `fpall_pkg` fmt type: FP32 / FP16 (FP16 in low lane).
- `i_req_x`, `i_req_y` in [NUM_REQ] x 32: operands.
- `o_fpu_opcode`, `o_fpu_fmt`, `o_fpu_x`, `o_fpu_y` out: registered drive to `fpall_shared`.
- `o_fpu_valid` out 1: registered; issue stage holds a real operation.
- `i_fpu_r` in 32: `fpall_shared` R.
- `o_rsp_valid` out [NUM_REQ]: one-hot result strobe.
- `o_rsp_data` out 32: result, shared by all requesters.
- `o_issue_cnt` out 32: total accepted operations, wraps.

## Operation
- Arbitration each cycle over `i_req_valid`; candidate search starts at pointer `rr_ptr`, first set bit in circular order wins.
- `o_req_ready[k]` = 1 only if k wins; 0 for all k when no valid. Ready depends combinationally on valid (documented exception; no valid-on-ready dependency allowed in clients).
- Handshake = `i_req_valid[k] & o_req_ready[k]`. On handshake: opcode/fmt/x/y of k captured into `o_fpu_*`, `o_fpu_valid`<=1, tag {valid=1, idx=k} enters tag pipe stage 0, `rr_ptr` <= (k+1) mod NUM_REQ, `o_issue_cnt`++ (wraps 0xFFFFFFFF->0).
- No handshake: `o_fpu_valid`<=0, `o_fpu_*` data hold last values (no toggling), tag stage 0 <= invalid, `rr_ptr` unchanged.
- Tag pipe: FPU_LAT+1 stages total counting issue stage; shifts every cycle, no stall.
- Output: when last tag stage valid with idx k: `o_rsp_valid` = one-hot k, `o_rsp_data` = `i_fpu_r` (combinational pass-through). Otherwise `o_rsp_valid`=0, `o_rsp_data`=0.
- No response backpressure: requesters must consume on strobe. No ordering guarantee across requesters beyond issue order; per-requester results return in issue order.
- Arithmetic, rounding, special values are entirely `fpall_shared`'s; arbiter never alters data.

## Timing
- Throughput: 1 op/cycle aggregate; single always-valid requester issues every cycle.
- Latency: handshake in cycle t -> `o_fpu_valid`=1 cycle t+1 -> `o_rsp_valid` in cycle t+1+FPU_LAT (FPU_LAT=0: t+1).
- Fairness: with all requesters valid continuously, each granted exactly once per NUM_REQ cycles.
- Reset (any cycle, incl. mid-operation): `o_fpu_valid`=0, `o_fpu_opcode`=OP_ADD, `o_fpu_fmt`=FP32, `o_fpu_x`=`o_fpu_y`=0, all tags invalid, `rr_ptr`=0, `o_issue_cnt`=0; `o_req_ready`=0 while `i_rst`=1. In-flight operations are dropped: no `o_rsp_valid` for them after reset.
- First grant after reset release goes to lowest-index valid requester.

## Configuration
- `FPALL_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest index always wins, `rr_ptr` logic removed; all other behaviour identical (starvation of high indices allowed).

## Test plan
- Single op: req0 FP32 ADD x=0x3F800000 y=0x40000000, FPU_LAT=0 -> ready0 same cycle, `o_rsp_valid`=0001 and data 0x40400000 next cycle; `o_issue_cnt`=1.
- Contention: req0..3 all valid FP32 MUL x=0x40000000 y=0x40400000 for 8 cycles (RR_EN) -> grants 0,1,2,3,0,1,2,3; each rsp 0x40C00000 to matching index; count=8.
- Fixed priority (no RR_EN): req0 and req2 always valid -> req2 never granted over 8 cycles.
- FP16 + latency: FPU_LAT=2, req1 FP16 ADD x=0x00003C00 y=0x00003C00 at cycle t -> `o_rsp_valid[1]` at t+3, data[15:0]=0x4000.
- Reset mid-flight: FPU_LAT=2, issue req3 op, assert `i_rst` next cycle for 1 cycle -> no `o_rsp_valid` ever for it; all outputs at reset values; next grant to lowest valid index.
- Idle gap: valid pulses with 2 idle cycles between -> `o_fpu_valid` low in gaps, `o_fpu_x/y` unchanged, no spurious `o_rsp_valid`.
